operand_fetch: RTL and testbench
================================

# operand_fetch

Operand fetch stage sitting directly upstream of the CPU register file. It takes a decoded instruction's source-register request and sequences the file's single read port: first rs1, then rs2 or an immediate. It latches both operands and presents them to the ALU with a valid/ready handshake. It snoops the write-back port so that held operands never go stale.

## Interface
- `addr_width`, default 4: register address width; the file holds 1<<addr_width registers.
- `data_width`, default 16: operand and register width.

- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous abort of any in-flight or held request.
- `req_valid`  in  1  decode presents a request.
- `req_ready`  out  1  stage can accept a request this cycle.
- `req_rs1`  in  addr_width  source register A.
- `req_rs2`  in  addr_width  source register B.
- `req_use_rs2`  in  1  1: B from register file; 0: B = `req_imm`.
- `req_imm`  in  data_width  immediate operand.
- `rf_radr`  out  addr_width  to register file read address.
- `rf_dout`  in  data_width  register file read data; valid at the posedge that ends the cycle in which `rf_radr` was driven.
- `wb_we`  in  1  write-back strobe; same signal that drives the file's write enable.
- `wb_adr`  in  addr_width  write-back address.
- `wb_data`  in  data_width  write-back data.
- `op_valid`  out  1  operands held and valid.
- `op_ready`  in  1  ALU consumes operands.
- `op_a`, `op_b`  out  data_width  latched operands.

## Operation
- States: IDLE, RD_A, RD_B, HOLD.
- `req_ready` = (state==IDLE) | (state==HOLD & op_ready), with `flush`=0.
- IDLE:
  - On req_valid & req_ready, latch rs1, rs2, use_rs2 and imm, then go to RD_A.
- RD_A:
  - Drive `rf_radr`=rs1 and capture `op_a` at cycle end.
  - Next state is RD_B if use_rs2=1.
  - Otherwise load `op_b`=imm and go to HOLD.
- RD_B:
  - Drive `rf_radr`=rs2, capture `op_b`, then go to HOLD.
- HOLD:
  - `op_valid`=1.
  - If op_ready & req_valid: accept the new request and go to RD_A.
  - If op_ready & !req_valid: go to IDLE.
  - Otherwise stay in HOLD.
- Bypass on capture: if wb_we=1 in the capture cycle and wb_adr equals the address being read, capture `wb_data` instead of `rf_dout`. That write lands after the file's negedge read.
- Snoop in HOLD: each cycle in HOLD (including the consuming cycle), if wb_we=1 and wb_adr matches rs1, `op_a` ← wb_data. Likewise for `op_b` when use_rs2=1 and wb_adr matches rs2. An immediate `op_b` is never modified.
- rs1==rs2: both operands are bypassed or snooped identically.
- `rf_radr` in IDLE/HOLD holds its last driven value.
- flush (priority below reset, above everything else): next state IDLE and `op_valid`=0. Operand registers and `rf_radr` are unchanged; any concurrent request is not accepted.
- Reset mid-operation: identical to flush, plus all registers cleared.

## Timing
- Reset values:
  - state IDLE, `op_valid` 0, `op_a` 0, `op_b` 0, `rf_radr` 0.
  - `req_ready` 1 in the first cycle after reset.
- Latency from the accept edge (cycle 0):
  - Register B: RD_A in cycle 1, RD_B in cycle 2, `op_valid` high in cycle 3.
  - Immediate B: `op_valid` high in cycle 2.
- Throughput with op_ready held high:
  - Register B: one operation per 3 cycles.
  - Immediate B: one operation per 2 cycles.
- All outputs registered except `req_ready` (combinational from state, op_ready and flush).
- Width rules: no arithmetic; address compares are full addr_width; data passes through unmodified.

## Structure
- Shared package `cpu_pkg`:
  - state encoding constants OF_IDLE, OF_RD_A, OF_RD_B, OF_HOLD (2 bits).
  - default widths 4/16, shared with the register file.
- One sub-module, `wb_bypass`:
  - inputs: current operand value, its address, wb_we, wb_adr, wb_data, and an enable.
  - output: the selected value.
  - instantiated twice, for A and B; used for both capture bypass and HOLD snoop.

## Test plan
- Preload r2=0x1234, r5=0xBEEF. Request rs1=2, rs2=5, use_rs2=1 at cycle 0 → `rf_radr` 2 then 5; cycle 3 `op_valid`=1, `op_a`=0x1234, `op_b`=0xBEEF.
- Request rs1=3, use_rs2=0, imm=0x00FF → `op_valid` in cycle 2, `op_b`=0x00FF; a write to r3 in HOLD updates `op_a`; a write to any register leaves `op_b`=0x00FF.
- wb_we=1, wb_adr=2, wb_data=0xAAAA in the RD_A cycle for rs1=2 → `op_a`=0xAAAA (not the old 0x1234).
- Hold op_ready=0 for 4 cycles, with a write r5=0x5555 in cycle 2 of HOLD → `op_b`=0x5555 and `op_valid` stays 1 throughout.
- op_ready=1 and req_valid=1 in the same HOLD cycle → back-to-back accept; next `op_valid` exactly 3 cycles later with no gap beyond RD_A/RD_B.
- flush, then (separately) reset, asserted in RD_B → next cycle IDLE, `op_valid`=0, `req_ready`=1; after reset `op_a`=`op_b`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file widths and
// operand fetch state encoding.
package cpu_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    OF_IDLE = 2'd0,
    OF_RD_A = 2'd1,
    OF_RD_B = 2'd2,
    OF_HOLD = 2'd3
  } of_state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Operand fetch bus: decode request, register file port,
// write-back snoop and ALU operand handshake.
interface operand_fetch_if #(
  parameter int addr_width = 4,
  parameter int data_width = 16
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [addr_width-1:0] req_rs1;
  logic [addr_width-1:0] req_rs2;
  logic                  req_use_rs2;
  logic [data_width-1:0] req_imm;
  logic [addr_width-1:0] rf_radr;
  logic [data_width-1:0] rf_dout;
  logic                  wb_we;
  logic [addr_width-1:0] wb_adr;
  logic [data_width-1:0] wb_data;
  logic                  op_valid;
  logic                  op_ready;
  logic [data_width-1:0] op_a;
  logic [data_width-1:0] op_b;

  modport master (
    output req_valid, req_rs1, req_rs2,
    output req_use_rs2, req_imm,
    input  req_ready,
    input  rf_radr,
    output rf_dout,
    output wb_we, wb_adr, wb_data,
    input  op_valid, op_a, op_b,
    output op_ready
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2,
    input  req_use_rs2, req_imm,
    output req_ready,
    output rf_radr,
    input  rf_dout,
    input  wb_we, wb_adr, wb_data,
    output op_valid, op_a, op_b,
    input  op_ready
  );

endinterface

// File: rtl/wb_bypass.sv
// Selects write-back data over an operand value when the
// write targets the operand's register.
module wb_bypass #(
  parameter int addr_width = 4,
  parameter int data_width = 16
) (
  input  logic [data_width-1:0] cur,
  input  logic [addr_width-1:0] adr,
  input  logic                  en,
  input  logic                  wb_we,
  input  logic [addr_width-1:0] wb_adr,
  input  logic [data_width-1:0] wb_data,
  output logic [data_width-1:0] sel
);

  logic hit;

  assign hit = en & wb_we & (wb_adr == adr);
  assign sel = hit ? wb_data : cur;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: sequences the single register file
// read port and holds operands for the ALU.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int addr_width = ADDR_WIDTH,
  parameter int data_width = DATA_WIDTH
) (
  input logic clk,
  input logic reset,
  input logic flush,
  operand_fetch_if.slave bus
);

  of_state_t state, state_next;

  logic                  ready;
  logic                  accept;
  logic [addr_width-1:0] rs1_q;
  logic [addr_width-1:0] rs2_q;
  logic                  use_rs2_q;
  logic [data_width-1:0] imm_q;
  logic [addr_width-1:0] radr_q;
  logic                  valid_q;
  logic [data_width-1:0] op_a_q;
  logic [data_width-1:0] op_b_q;
  logic [data_width-1:0] a_cur, b_cur;
  logic [data_width-1:0] a_sel, b_sel;

  always_ff @(posedge clk) begin
    if (reset) state <= OF_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    unique case (state)
      OF_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) state_next = OF_RD_A;
      end
      OF_RD_A: begin
        state_next = use_rs2_q ? OF_RD_B : OF_HOLD;
      end
      OF_RD_B: begin
        state_next = OF_HOLD;
      end
      OF_HOLD: begin
        ready = bus.op_ready;
        if (bus.op_ready)
          state_next = bus.req_valid ? OF_RD_A : OF_IDLE;
      end
      default: state_next = OF_IDLE;
    endcase
    if (flush) begin
      ready      = 1'b0;
      state_next = OF_IDLE;
    end
  end

  assign accept = bus.req_valid & ready;

  // Capture cycles bypass rf_dout; HOLD snoops the held value.
  assign a_cur = (state == OF_RD_A) ? bus.rf_dout : op_a_q;
  assign b_cur = (state == OF_RD_B) ? bus.rf_dout : op_b_q;

  wb_bypass #(
    .addr_width(addr_width),
    .data_width(data_width)
  ) u_byp_a (
    .cur    (a_cur),
    .adr    (rs1_q),
    .en     (1'b1),
    .wb_we  (bus.wb_we),
    .wb_adr (bus.wb_adr),
    .wb_data(bus.wb_data),
    .sel    (a_sel)
  );

  wb_bypass #(
    .addr_width(addr_width),
    .data_width(data_width)
  ) u_byp_b (
    .cur    (b_cur),
    .adr    (rs2_q),
    .en     (use_rs2_q),
    .wb_we  (bus.wb_we),
    .wb_adr (bus.wb_adr),
    .wb_data(bus.wb_data),
    .sel    (b_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_rs2_q <= 1'b0;
      imm_q     <= '0;
      radr_q    <= '0;
      valid_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      valid_q <= (state_next == OF_HOLD);
      if (!flush) begin
        if (accept) begin
          rs1_q     <= bus.req_rs1;
          rs2_q     <= bus.req_rs2;
          use_rs2_q <= bus.req_use_rs2;
          imm_q     <= bus.req_imm;
          radr_q    <= bus.req_rs1;
        end
        unique case (state)
          OF_RD_A: begin
            op_a_q <= a_sel;
            if (use_rs2_q) radr_q <= rs2_q;
            else           op_b_q <= imm_q;
          end
          OF_RD_B: op_b_q <= b_sel;
          OF_HOLD: begin
            op_a_q <= a_sel;
            op_b_q <= b_sel;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rf_radr   = radr_q;
  assign bus.op_valid  = valid_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch with a behavioural
// register file (negedge read, posedge write).
module tb_operand_fetch;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  operand_fetch_if #(.addr_width(4), .data_width(16)) bus ();

  operand_fetch #(.addr_width(4), .data_width(16)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [16];

  always @(posedge clk)
    if (bus.wb_we) rf[bus.wb_adr] <= bus.wb_data;

  always @(negedge clk)
    bus.rf_dout <= rf[bus.rf_radr];

  typedef struct {
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        use_rs2;
    logic [15:0] imm;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] sb [$];
  int          tests = 0;
  int          fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic accept_req(input logic [3:0] r1, input logic [3:0] r2,
                            input logic u, input logic [15:0] im);
    bus.req_valid   = 1'b1;
    bus.req_rs1     = r1;
    bus.req_rs2     = r2;
    bus.req_use_rs2 = u;
    bus.req_imm     = im;
    #1;
    check("req_ready_at_accept", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Called in cycle 1 after the accept edge; leaves time in the
  // first op_valid cycle.
  task automatic wait_valid(input string nm, input logic [3:0] r1,
                            input logic [3:0] r2, input logic u);
    int cyc;
    logic [31:0] e;
    cyc = 1;
    check({nm, "_radr_a"}, {28'd0, bus.rf_radr}, {28'd0, r1});
    while (!bus.op_valid && cyc < 8) begin
      tick();
      cyc++;
      if (cyc == 2 && u)
        check({nm, "_radr_b"}, {28'd0, bus.rf_radr}, {28'd0, r2});
    end
    check({nm, "_latency"}, cyc, u ? 32'd3 : 32'd2);
    if (sb.size() == 0) begin
      check({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({nm, "_op_a"}, {16'd0, bus.op_a}, {16'd0, e[31:16]});
      check({nm, "_op_b"}, {16'd0, bus.op_b}, {16'd0, e[15:0]});
    end
  endtask

  initial begin
    vecs[0] = '{4'd2,  4'd5, 1'b1, 16'h0000, 16'h1234, 16'hBEEF};
    vecs[1] = '{4'd3,  4'd0, 1'b0, 16'h00FF, 16'h3333, 16'h00FF};
    vecs[2] = '{4'd5,  4'd2, 1'b1, 16'h0000, 16'hBEEF, 16'h1234};
    vecs[3] = '{4'd2,  4'd2, 1'b1, 16'h0000, 16'h1234, 16'h1234};
    vecs[4] = '{4'd15, 4'd0, 1'b1, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[5] = '{4'd7,  4'd9, 1'b0, 16'hA5A5, 16'h7777, 16'hA5A5};

    reset           = 1'b1;
    flush           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_rs1     = '0;
    bus.req_rs2     = '0;
    bus.req_use_rs2 = 1'b0;
    bus.req_imm     = '0;
    bus.op_ready    = 1'b0;
    bus.wb_we       = 1'b0;
    bus.wb_adr      = '0;
    bus.wb_data     = '0;

    // Preload the file through the write port while in reset.
    for (int i = 0; i < 18; i++) begin
      bus.wb_we   = 1'b1;
      bus.wb_adr  = (i < 16) ? 4'(i) : ((i == 16) ? 4'd2 : 4'd5);
      bus.wb_data = (i < 16) ? 16'(i * 16'h1111)
                             : ((i == 16) ? 16'h1234 : 16'hBEEF);
      tick();
    end
    bus.wb_we = 1'b0;
    reset     = 1'b0;
    #1;
    check("rst_op_valid",  {31'd0, bus.op_valid},  32'd0);
    check("rst_op_a",      {16'd0, bus.op_a},      32'd0);
    check("rst_op_b",      {16'd0, bus.op_b},      32'd0);
    check("rst_rf_radr",   {28'd0, bus.rf_radr},   32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    bus.op_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      sb.push_back({vecs[v].exp_a, vecs[v].exp_b});
      accept_req(vecs[v].rs1, vecs[v].rs2, vecs[v].use_rs2, vecs[v].imm);
      wait_valid($sformatf("vec%0d", v), vecs[v].rs1, vecs[v].rs2,
                 vecs[v].use_rs2);
      tick();
      check($sformatf("vec%0d_consumed", v), {31'd0, bus.op_valid}, 32'd0);
    end

    // Immediate operand with HOLD snoop on A only.
    bus.op_ready = 1'b0;
    sb.push_back({16'h3333, 16'h00FF});
    accept_req(4'd3, 4'd4, 1'b0, 16'h00FF);
    wait_valid("imm", 4'd3, 4'd4, 1'b0);
    bus.wb_we = 1'b1; bus.wb_adr = 4'd3; bus.wb_data = 16'h7777;
    tick();
    check("imm_snoop_a", {16'd0, bus.op_a}, 32'h7777);
    bus.wb_adr = 4'd4; bus.wb_data = 16'h4444;
    tick();
    bus.wb_we = 1'b0;
    check("imm_b_kept", {16'd0, bus.op_b}, 32'h00FF);
    check("imm_a_kept", {16'd0, bus.op_a}, 32'h7777);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;

    // Capture bypass in RD_A, then a long HOLD with a snoop on B.
    accept_req(4'd2, 4'd5, 1'b1, 16'h0000);
    check("byp_radr_a", {28'd0, bus.rf_radr}, 32'd2);
    bus.wb_we = 1'b1; bus.wb_adr = 4'd2; bus.wb_data = 16'hAAAA;
    tick();
    bus.wb_we = 1'b0;
    check("byp_radr_b", {28'd0, bus.rf_radr}, 32'd5);
    tick();
    check("byp_valid", {31'd0, bus.op_valid}, 32'd1);
    check("byp_op_a",  {16'd0, bus.op_a}, 32'hAAAA);
    check("byp_op_b",  {16'd0, bus.op_b}, 32'hBEEF);
    for (int h = 1; h <= 4; h++) begin
      check($sformatf("hold%0d_valid", h), {31'd0, bus.op_valid}, 32'd1);
      bus.wb_we = (h == 2); bus.wb_adr = 4'd5; bus.wb_data = 16'h5555;
      tick();
    end
    bus.wb_we = 1'b0;
    check("hold_op_b",  {16'd0, bus.op_b}, 32'h5555);
    check("hold_op_a",  {16'd0, bus.op_a}, 32'hAAAA);
    check("hold_valid", {31'd0, bus.op_valid}, 32'd1);

    // Back-to-back accept from HOLD, with an RD_B capture bypass.
    bus.op_ready = 1'b1;
    accept_req(4'd5, 4'd2, 1'b1, 16'h0000);
    check("b2b_c1_valid", {31'd0, bus.op_valid}, 32'd0);
    check("b2b_radr_a",   {28'd0, bus.rf_radr}, 32'd5);
    tick();
    check("b2b_radr_b", {28'd0, bus.rf_radr}, 32'd2);
    bus.wb_we = 1'b1; bus.wb_adr = 4'd2; bus.wb_data = 16'hCCCC;
    tick();
    bus.wb_we = 1'b0;
    check("b2b_c3_valid", {31'd0, bus.op_valid}, 32'd1);
    check("b2b_op_a", {16'd0, bus.op_a}, 32'h5555);
    check("b2b_op_b", {16'd0, bus.op_b}, 32'hCCCC);
    tick();
    bus.op_ready = 1'b0;

    // Flush in RD_B with a competing request.
    accept_req(4'd3, 4'd4, 1'b1, 16'h0000);
    tick();
    check("fl_radr_b", {28'd0, bus.rf_radr}, 32'd4);
    flush = 1'b1;
    bus.req_valid = 1'b1; bus.req_rs1 = 4'd9; bus.req_use_rs2 = 1'b1;
    #1;
    check("fl_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("fl_op_valid",  {31'd0, bus.op_valid},  32'd0);
    check("fl_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("fl_radr",      {28'd0, bus.rf_radr},   32'd4);
    check("fl_op_a",      {16'd0, bus.op_a},      32'h7777);
    check("fl_op_b",      {16'd0, bus.op_b},      32'hCCCC);
    tick();
    tick();
    check("fl_idle_valid", {31'd0, bus.op_valid}, 32'd0);
    check("fl_idle_radr",  {28'd0, bus.rf_radr},  32'd4);

    // Reset in RD_B.
    accept_req(4'd2, 4'd5, 1'b1, 16'h0000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mr_op_valid",  {31'd0, bus.op_valid},  32'd0);
    check("mr_op_a",      {16'd0, bus.op_a},      32'd0);
    check("mr_op_b",      {16'd0, bus.op_b},      32'd0);
    check("mr_radr",      {28'd0, bus.rf_radr},   32'd0);
    check("mr_req_ready", {31'd0, bus.req_ready}, 32'd1);

    bus.op_ready = 1'b1;
    sb.push_back({16'h5555, 16'h7777});
    accept_req(4'd5, 4'd3, 1'b1, 16'h0000);
    wait_valid("post_rst", 4'd5, 4'd3, 1'b1);
    tick();
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
